// File: rtl/fetch_queue_pkg.sv
// Shared field geometry and decoded-field type for the fetch queue and later decode stages.
// Field layout from MSB to LSB: imb | ra | imm (rb = top of imm) | opc | rc | cond | cmp.
package fetch_pkg;

    localparam int REG_W    = 4;
    localparam int IMM_W    = 14;
    localparam int OPC_W    = 5;
    localparam int COND_W   = 3;
    localparam int DATA_W   = 1 + REG_W + IMM_W + OPC_W + REG_W + COND_W + 1;

    localparam int CMP_POS  = 0;
    localparam int COND_LSB = 1;
    localparam int RC_LSB   = COND_LSB + COND_W;
    localparam int OPC_LSB  = RC_LSB + REG_W;
    localparam int IMM_LSB  = OPC_LSB + OPC_W;
    localparam int RB_LSB   = IMM_LSB + IMM_W - REG_W;
    localparam int RA_LSB   = IMM_LSB + IMM_W;
    localparam int IMB_POS  = RA_LSB + REG_W;

    typedef struct packed {
        logic              imb;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [IMM_W-1:0]  imm;
        logic [OPC_W-1:0]  opc;
        logic [REG_W-1:0]  rc;
        logic [COND_W-1:0] cond;
        logic              cmp;
    } instr_fields_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake and decoded-head bundle between fetch, the queue and execute.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
);
    import fetch_pkg::*;

    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_instr;
    logic [PC_W-1:0]               in_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [PC_W-1:0]               out_pc;
    logic                          imb;
    logic [REG_W-1:0]              ra;
    logic [REG_W-1:0]              rb;
    logic [IMM_W-1:0]              imm;
    logic [DATA_W-1:0]             imm_sext;
    logic [OPC_W-1:0]              opc;
    logic [REG_W-1:0]              rc;
    logic [COND_W-1:0]             cond;
    logic                          cmp;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, imb, ra, rb, imm, imm_sext,
               opc, rc, cond, cmp, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, imb, ra, rb, imm, imm_sext,
               opc, rc, cond, cmp, count
    );

endinterface

// File: rtl/fetch_queue_decode.sv
// Purely combinational split of an instruction word into its fields plus sign-extended immediate.
module instr_field_decode
    import fetch_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output instr_fields_t     fields,
    output logic [DATA_W-1:0] imm_sext
);

    assign fields.imb  = instr[IMB_POS];
    assign fields.ra   = instr[RA_LSB +: REG_W];
    assign fields.rb   = instr[RB_LSB +: REG_W];
    assign fields.imm  = instr[IMM_LSB +: IMM_W];
    assign fields.opc  = instr[OPC_LSB +: OPC_W];
    assign fields.rc   = instr[RC_LSB +: REG_W];
    assign fields.cond = instr[COND_LSB +: COND_W];
    assign fields.cmp  = instr[CMP_POS];
    assign imm_sext    = sext_imm(instr[IMM_LSB +: IMM_W]);

endmodule

// File: rtl/fetch_queue.sv
// PC-tagged instruction FIFO with flush; presents the decoded head entry, zeroed when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (IMM_W < REG_W) begin : g_bad_imm_w
        $error("IMM_W must be at least REG_W");
    end

    logic [DATA_W-1:0] word_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;
    instr_fields_t     head_fields_s;
    logic [DATA_W-1:0] head_sext_s;

    // Readiness depends on occupancy only, so a full queue stays closed even while popping.
    assign in_ready_s  = (count_r < CNT_W'(DEPTH));
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    // Pointer and occupancy bookkeeping; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (bus.flush) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push_s && !bus.flush) begin
            word_mem[wr_ptr_r] <= bus.in_instr;
            pc_mem[wr_ptr_r]   <= bus.in_pc;
        end
    end

    instr_field_decode u_decode (
        .instr    (word_mem[rd_ptr_r]),
        .fields   (head_fields_s),
        .imm_sext (head_sext_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.count     = count_r;
    assign bus.out_pc    = out_valid_s ? pc_mem[rd_ptr_r] : {PC_W{1'b0}};
    assign bus.imb       = out_valid_s ? head_fields_s.imb  : 1'b0;
    assign bus.ra        = out_valid_s ? head_fields_s.ra   : {REG_W{1'b0}};
    assign bus.rb        = out_valid_s ? head_fields_s.rb   : {REG_W{1'b0}};
    assign bus.imm       = out_valid_s ? head_fields_s.imm  : {IMM_W{1'b0}};
    assign bus.opc       = out_valid_s ? head_fields_s.opc  : {OPC_W{1'b0}};
    assign bus.rc        = out_valid_s ? head_fields_s.rc   : {REG_W{1'b0}};
    assign bus.cond      = out_valid_s ? head_fields_s.cond : {COND_W{1'b0}};
    assign bus.cmp       = out_valid_s ? head_fields_s.cmp  : 1'b0;
    assign bus.imm_sext  = out_valid_s ? head_sext_s        : {DATA_W{1'b0}};

endmodule
